// File: rtl/arb_dispatch_pkg.sv
// Shared types and helpers for the arbiter grant dispatcher.
// Grant vectors handed to the helpers are zero-extended to 32 bits,
// so the dispatcher supports up to 32 requestors.
package arb_dispatch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } disp_state_t;

  localparam int GRANT_VEC_W = 32;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] onehot_to_idx(input logic [GRANT_VEC_W-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = GRANT_VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic popcount_gt1(input logic [GRANT_VEC_W-1:0] vec);
    return |(vec & (vec - GRANT_VEC_W'(1)));
  endfunction

endpackage

// File: rtl/arb_skid_buffer.sv
// Two-entry valid/ready register slice. vld_p0/data_p0 is the output
// register, vld_p1/data_p1 the skid slot that catches the beat accepted
// while the output is stalled. in_ready depends only on local state, so
// there is no combinational path from out_ready back to in_ready.
module arb_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             vld_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] data_p1;
  logic             push;
  logic             load_p0;

  assign in_ready  = ~vld_p1;
  assign push      = in_valid & in_ready;
  assign load_p0   = ~vld_p0 | out_ready;
  assign out_valid = vld_p0;
  // Payload is forced to zero while empty so the port reads clean after reset.
  assign out_data  = vld_p0 ? data_p0 : '0;

  // Occupancy: the output slot refills from the skid slot first, else from the input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p0 <= vld_p1 | push;
      vld_p1 <= 1'b0;
    end else if (push) begin
      vld_p1 <= 1'b1;
    end
  end

  // Payload registers follow the occupancy moves; no reset needed on data.
  always_ff @(posedge clk) begin
    if (load_p0) begin
      data_p0 <= vld_p1 ? data_p1 : in_data;
    end else if (push) begin
      data_p1 <= in_data;
    end
  end

endmodule

// File: rtl/arb_grant_dispatcher.sv
// Grant dispatcher: takes the arbiter's registered one-hot grant, locks
// ownership to one requestor for a packet, forwards that requestor's beats
// through a skid buffer and pulses done[owner] when the packet completes.
// Optional stall timeout: define ARB_DISPATCH_TIMEOUT_EN to add the
// timeout_err port and abandon a packet whose owner stalls too long.
module arb_grant_dispatcher
  import arb_dispatch_pkg::*;
#(
  parameter int NUM_REQUESTORS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQUESTORS-1:0]            grant,
  input  logic                                 grant_valid,
  input  logic [NUM_REQUESTORS-1:0]            src_valid,
  input  logic [NUM_REQUESTORS*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_REQUESTORS-1:0]            src_last,
  output logic [NUM_REQUESTORS-1:0]            src_ready,
  output logic [NUM_REQUESTORS-1:0]            done,
  output logic                                 busy,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic [$clog2(NUM_REQUESTORS)-1:0]    out_src,
  input  logic                                 out_ready,
  output logic                                 grant_err,
  output logic                                 burst_trunc
`ifdef ARB_DISPATCH_TIMEOUT_EN
  ,
  output logic                                 timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQUESTORS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int PAY_W = DATA_WIDTH + 1 + IDX_W;

  disp_state_t         state, state_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [NUM_REQUESTORS-1:0] done_nxt;
  logic                accept;
  logic                last_eff;
  logic                skid_in_ready;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PAY_W-1:0]    skid_in_data;
  logic [PAY_W-1:0]    skid_out_data;

`ifdef ARB_DISPATCH_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0]  stall_cnt, stall_nxt;
  logic                tmo_nxt;
`endif

  assign sel_data     = src_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign skid_in_data = {sel_data, last_eff, owner};

  // Ownership FSM: IDLE latches the lowest granted requestor, XFER forwards its beats.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    done_nxt     = '0;
    src_ready    = '0;
    busy         = 1'b0;
    accept       = 1'b0;
    last_eff     = 1'b0;
    grant_err    = 1'b0;
    burst_trunc  = 1'b0;
`ifdef ARB_DISPATCH_TIMEOUT_EN
    stall_nxt    = '0;
    tmo_nxt      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        beat_cnt_nxt = '0;
        if (grant_valid && |grant) begin
          owner_nxt = IDX_W'(onehot_to_idx(GRANT_VEC_W'(grant)));
          grant_err = popcount_gt1(GRANT_VEC_W'(grant));
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        busy             = 1'b1;
        src_ready[owner] = skid_in_ready;
        accept           = src_valid[owner] & skid_in_ready;
        last_eff         = src_last[owner] | (beat_cnt == CNT_W'(MAX_BURST - 1));
        if (accept) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (last_eff) begin
            state_nxt       = ST_IDLE;
            beat_cnt_nxt    = '0;
            done_nxt[owner] = 1'b1;
            burst_trunc     = ~src_last[owner];
          end
        end
`ifdef ARB_DISPATCH_TIMEOUT_EN
        // The exit decision is taken one cycle early so that done and
        // timeout_err land in the TIMEOUT_CYCLES-th consecutive stall cycle.
        if (!src_valid[owner]) begin
          if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 2)) begin
            state_nxt       = ST_IDLE;
            beat_cnt_nxt    = '0;
            done_nxt[owner] = 1'b1;
            tmo_nxt         = 1'b1;
          end else begin
            stall_nxt = stall_cnt + STALL_W'(1);
          end
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: state, owner, beat count and the registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      done     <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
      done     <= done_nxt;
    end
  end

`ifdef ARB_DISPATCH_TIMEOUT_EN
  // Stall counter and the timeout pulse that accompanies the abandon-done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      stall_cnt   <= stall_nxt;
      timeout_err <= tmo_nxt;
    end
  end
`endif

  arb_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out_data)
  );

  assign {out_data, out_last, out_src} = skid_out_data;

endmodule

// File: tb/tb_arb_grant_dispatcher.sv
// Self-checking bench for arb_grant_dispatcher (default parameters).
// Define ARB_DISPATCH_TIMEOUT_EN to build and exercise the timeout variant.
module tb_arb_grant_dispatcher;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [N-1:0]  src_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]  src_last;
  logic [N-1:0]  src_ready;
  logic [N-1:0]  done;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_src;
  logic          out_ready;
  logic          grant_err;
  logic          burst_trunc;
`ifdef ARB_DISPATCH_TIMEOUT_EN
  logic          timeout_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  arb_grant_dispatcher #(
    .NUM_REQUESTORS (N),
    .DATA_WIDTH     (DW),
    .MAX_BURST      (MB),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .grant       (grant),
    .grant_valid (grant_valid),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .done        (done),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .grant_err   (grant_err),
    .burst_trunc (burst_trunc)
`ifdef ARB_DISPATCH_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [31:0] d);
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = d + (32'(i) << 28);
  endtask

  task automatic drive_idle();
    grant_valid = 1'b0; grant = '0; src_valid = '0; src_last = '0;
    src_data = '0; out_ready = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " src_ready"}, src_ready, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " out_src"}, out_src, 0);
    chk({tag, " grant_err"}, grant_err, 0);
    chk({tag, " burst_trunc"}, burst_trunc, 0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        gv;
    logic [3:0]  g;
    logic [3:0]  sv;
    logic [3:0]  sl;
    logic [31:0] d;
    logic        e_busy;
    logic [3:0]  e_srdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ol;
    logic [1:0]  e_os;
    logic [3:0]  e_done;
    logic        e_gerr;
  } vec_t;

  function automatic vec_t mk(logic gv, logic [3:0] g, logic [3:0] sv, logic [3:0] sl,
                              logic [31:0] d, logic eb, logic [3:0] esr, logic eov,
                              logic [31:0] eod, logic eol, logic [1:0] eos,
                              logic [3:0] edn, logic eg);
    vec_t v;
    v.gv = gv; v.g = g; v.sv = sv; v.sl = sl; v.d = d;
    v.e_busy = eb; v.e_srdy = esr; v.e_ov = eov; v.e_od = eod; v.e_ol = eol;
    v.e_os = eos; v.e_done = edn; v.e_gerr = eg;
    return v;
  endfunction

  task automatic run_table();
    vec_t vec [11];
    // Single 3-beat packet from src2; a grant arriving in the first XFER cycle is dropped.
    vec[0]  = mk(1, 4'b0100, 4'b0100, 4'b0000, 32'hA0, 0, 4'b0000, 0, 32'h0,         0, 0, 4'b0000, 0);
    vec[1]  = mk(1, 4'b0001, 4'b0100, 4'b0000, 32'hA0, 1, 4'b0100, 0, 32'h0,         0, 0, 4'b0000, 0);
    vec[2]  = mk(0, 4'b0000, 4'b0100, 4'b0000, 32'hA1, 1, 4'b0100, 1, 32'h2000_00A0, 0, 2, 4'b0000, 0);
    vec[3]  = mk(0, 4'b0000, 4'b0100, 4'b0100, 32'hA2, 1, 4'b0100, 1, 32'h2000_00A1, 0, 2, 4'b0000, 0);
    vec[4]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,  0, 4'b0000, 1, 32'h2000_00A2, 1, 2, 4'b0100, 0);
    vec[5]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,  0, 4'b0000, 0, 32'h0,         0, 0, 4'b0000, 0);
    // Multi-hot grant: owner 1, src3 never gets ready; grant during XFER ignored.
    vec[6]  = mk(1, 4'b1010, 4'b1010, 4'b1010, 32'hB0, 0, 4'b0000, 0, 32'h0,         0, 0, 4'b0000, 1);
    vec[7]  = mk(1, 4'b0001, 4'b1010, 4'b1010, 32'hB0, 1, 4'b0010, 0, 32'h0,         0, 0, 4'b0000, 0);
    vec[8]  = mk(0, 4'b0000, 4'b1000, 4'b1000, 32'hB0, 0, 4'b0000, 1, 32'h1000_00B0, 1, 1, 4'b0010, 0);
    // grant_valid with an empty grant is ignored.
    vec[9]  = mk(1, 4'b0000, 4'b1000, 4'b1000, 32'hB0, 0, 4'b0000, 0, 32'h0,         0, 0, 4'b0000, 0);
    vec[10] = mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,  0, 4'b0000, 0, 32'h0,         0, 0, 4'b0000, 0);
    for (int r = 0; r < 11; r++) begin
      @(posedge clk); #1;
      grant_valid = vec[r].gv; grant = vec[r].g;
      src_valid = vec[r].sv; src_last = vec[r].sl;
      set_lanes(vec[r].d); out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("row%0d busy", r), busy, vec[r].e_busy);
      chk($sformatf("row%0d src_ready", r), src_ready, vec[r].e_srdy);
      chk($sformatf("row%0d out_valid", r), out_valid, vec[r].e_ov);
      chk($sformatf("row%0d out_data", r), out_data, vec[r].e_od);
      chk($sformatf("row%0d out_last", r), out_last, vec[r].e_ol);
      chk($sformatf("row%0d out_src", r), out_src, vec[r].e_os);
      chk($sformatf("row%0d done", r), done, vec[r].e_done);
      chk($sformatf("row%0d grant_err", r), grant_err, vec[r].e_gerr);
      chk($sformatf("row%0d burst_trunc", r), burst_trunc, 0);
    end
  endtask

  // ---------------- hand-written sequences ----------------
  task automatic run_backpressure();
    int nacc = 0, nout = 0;
    logic got_done = 1'b0;
    @(posedge clk); #1;
    drive_idle(); grant_valid = 1'b1; grant = 4'b0100; out_ready = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      grant_valid = 1'b0; grant = '0;
      src_valid = (nacc < 3) ? 4'b0100 : 4'b0000;
      src_last  = (nacc == 2) ? 4'b0100 : 4'b0000;
      src_data  = '0; src_data[2*DW +: DW] = 32'hA0 + 32'(nacc);
      out_ready = (k > 5);
      @(negedge clk);
      if (k == 1) chk("bp ready open", src_ready, 4'b0100);
      if (k >= 3 && k <= 5) chk($sformatf("bp ready held k%0d", k), src_ready, 4'b0000);
      if (src_valid[2] && src_ready[2]) nacc++;
      if (out_valid && out_ready) begin
        chk($sformatf("bp data%0d", nout), out_data, 32'hA0 + 32'(nout));
        chk($sformatf("bp last%0d", nout), out_last, (nout == 2));
        nout++;
      end
      if (done == 4'b0100) got_done = 1'b1;
      if (got_done && nout == 3) break;
    end
    chk("bp beats in", nacc, 3);
    chk("bp beats out", nout, 3);
    chk("bp done seen", got_done, 1);
    idle_cycles(1);
    @(negedge clk);
    chk("bp busy after", busy, 0);
  endtask

  task automatic run_truncation();
    int nacc = 0, nout = 0, ntr = 0, trunc_at = -1;
    @(posedge clk); #1;
    drive_idle(); grant_valid = 1'b1; grant = 4'b0010;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      grant_valid = 1'b0; grant = '0;
      src_valid = 4'b0010; src_last = '0;
      src_data = '0; src_data[1*DW +: DW] = 32'h100 + 32'(nacc);
      @(negedge clk);
      if (burst_trunc) begin ntr++; trunc_at = nacc; end
      if (src_valid[1] && src_ready[1]) nacc++;
      if (out_valid) begin
        chk($sformatf("tr data%0d", nout), out_data, 32'h100 + 32'(nout));
        chk($sformatf("tr last%0d", nout), out_last, (nout == MB - 1));
        chk($sformatf("tr src%0d", nout), out_src, 1);
        nout++;
      end
      if (nout == MB) break;
    end
    chk("tr beats out", nout, MB);
    chk("tr pulses", ntr, 1);
    chk("tr pulse beat", trunc_at, MB - 1);
    chk("tr done", done, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("tr hold ready", src_ready, 0);
      chk("tr hold busy", busy, 0);
    end
    // Regrant for the remaining four beats, the last one carrying src_last.
    @(posedge clk); #1;
    grant_valid = 1'b1; grant = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      grant_valid = 1'b0; grant = '0;
      src_valid = (nacc < 20) ? 4'b0010 : 4'b0000;
      src_last  = (nacc == 19) ? 4'b0010 : 4'b0000;
      src_data = '0; src_data[1*DW +: DW] = 32'h100 + 32'(nacc);
      @(negedge clk);
      chk("tr2 no trunc", burst_trunc, 0);
      if (src_valid[1] && src_ready[1]) nacc++;
      if (out_valid) begin
        chk($sformatf("tr2 data%0d", nout), out_data, 32'h100 + 32'(nout));
        chk($sformatf("tr2 last%0d", nout), out_last, (nout == 19));
        nout++;
      end
      if (nout == 20) break;
    end
    chk("tr2 beats out", nout, 20);
    chk("tr2 done", done, 4'b0010);
    idle_cycles(2);
  endtask

  task automatic run_reset_mid();
    int nacc = 0;
    @(posedge clk); #1;
    drive_idle(); grant_valid = 1'b1; grant = 4'b0001; out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      grant_valid = 1'b0; grant = '0;
      src_valid = 4'b0001; src_data = '0; src_data[DW-1:0] = 32'h300 + 32'(nacc);
      @(negedge clk);
      if (src_valid[0] && src_ready[0]) nacc++;
      if (nacc == 2) break;
    end
    chk("rm beats before reset", nacc, 2);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rm in reset");
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle(); grant_valid = 1'b1; grant = 4'b0001;
    src_valid = 4'b0001; src_last = 4'b0001; src_data[DW-1:0] = 32'h3FF;
    @(negedge clk);
    chk("rm grant busy", busy, 0);
    @(posedge clk); #1;
    grant_valid = 1'b0; grant = '0;
    @(negedge clk);
    chk("rm ready", src_ready, 4'b0001);
    @(posedge clk); #1;
    src_valid = '0; src_last = '0;
    @(negedge clk);
    chk("rm out_valid", out_valid, 1);
    chk("rm out_data", out_data, 32'h3FF);
    chk("rm out_last", out_last, 1);
    chk("rm out_src", out_src, 0);
    chk("rm done", done, 4'b0001);
    chk("rm busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rm drained", out_valid, 0);
  endtask

`ifdef ARB_DISPATCH_TIMEOUT_EN
  task automatic run_timeout();
    int hit = -1;
    @(posedge clk); #1;
    drive_idle(); grant_valid = 1'b1; grant = 4'b0001;
    @(posedge clk); #1;
    grant_valid = 1'b0; grant = '0;
    src_valid = 4'b0001; src_data[DW-1:0] = 32'h55;
    @(negedge clk);
    chk("to first ready", src_ready, 4'b0001);
    for (int s = 1; s <= 80; s++) begin
      @(posedge clk); #1;
      src_valid = '0;
      @(negedge clk);
      if (timeout_err) begin
        hit = s;
        chk("to done", done, 4'b0001);
        chk("to busy", busy, 0);
        break;
      end
    end
    chk("to stall cycle", hit, 64);
    idle_cycles(2);
  endtask
`endif

  // ---------------- randomized run against a packet-level model ----------------
  logic [31:0] sdat [N][80];
  logic        slst [N][80];
  int          shd  [N];
  int          sln  [N];

  task automatic run_random();
    logic [34:0] expq [$];
    logic [34:0] eb;
    logic [3:0]  g, exp_done, exp_srdy;
    logic        took, multi, acc, fin, pop, drained, m_busy, m_trunc, lastf;
    logic [1:0]  m_owner;
    int          o, k, p, occ, m_left, cyc, pos, len;
    int          cand [$];
    for (int i = 0; i < N; i++) begin
      pos = 0;
      while (pos < 60) begin
        len = $urandom_range(1, 20);
        for (int j = 0; j < len; j++) begin
          sdat[i][pos] = {4'(i), 28'($urandom)};
          slst[i][pos] = (j == len - 1);
          pos++;
        end
      end
      sln[i] = pos;
      shd[i] = 0;
    end
    m_busy = 0; m_owner = 0; m_trunc = 0; m_left = 0; occ = 0; exp_done = 0; o = 0;
    drained = 0;
    for (cyc = 0; cyc < 6000 && !drained; cyc++) begin
      @(posedge clk); #1;
      took = 0; multi = 0; grant_valid = 0; grant = '0;
      if (!m_busy) begin
        cand.delete();
        for (int i = 0; i < N; i++) if (shd[i] < sln[i]) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
          o = cand[$urandom_range(0, cand.size() - 1)];
          g = 4'b1 << o;
          if ($urandom_range(0, 3) == 0)
            for (int b = o + 1; b < N; b++) if ($urandom_range(0, 1) == 1) g[b] = 1'b1;
          grant_valid = 1; grant = g; took = 1;
          multi = ($countones(g) > 1);
        end else if ($urandom_range(0, 9) == 0) begin
          grant_valid = 1;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        grant_valid = 1; grant = 4'($urandom_range(1, 15));
      end
      for (int i = 0; i < N; i++) begin
        if (shd[i] < sln[i]) begin
          src_valid[i] = ($urandom_range(0, 3) != 0);
          src_data[i*DW +: DW] = sdat[i][shd[i]];
          src_last[i] = slst[i][shd[i]];
        end else begin
          src_valid[i] = 0; src_data[i*DW +: DW] = $urandom; src_last[i] = 0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (took) begin
        k = 0; p = shd[o];
        forever begin
          lastf = slst[o][p] || (k == MB - 1);
          expq.push_back({sdat[o][p], lastf, 2'(o)});
          k++;
          if (lastf) break;
          p++;
        end
        m_left = k; m_trunc = !slst[o][p];
      end
      @(negedge clk);
      exp_srdy = m_busy ? (((occ < 2) ? 4'b1 : 4'b0) << m_owner) : 4'b0;
      acc = m_busy && src_valid[m_owner] && (occ < 2);
      fin = acc && (m_left == 1);
      chk($sformatf("rnd busy c%0d", cyc), busy, m_busy);
      chk($sformatf("rnd src_ready c%0d", cyc), src_ready, exp_srdy);
      chk($sformatf("rnd out_valid c%0d", cyc), out_valid, (occ > 0));
      chk($sformatf("rnd done c%0d", cyc), done, exp_done);
      chk($sformatf("rnd grant_err c%0d", cyc), grant_err, (took && multi));
      chk($sformatf("rnd burst_trunc c%0d", cyc), burst_trunc, (fin && m_trunc));
      pop = (occ > 0) && out_ready;
      if (pop) begin
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rnd beat c%0d: got %0h expected no beat", cyc, {out_data, out_last, out_src});
        end else begin
          eb = expq.pop_front();
          chk($sformatf("rnd beat c%0d", cyc), {out_data, out_last, out_src}, eb);
        end
      end
      exp_done = fin ? (4'b1 << m_owner) : 4'b0;
      if (acc) begin shd[m_owner]++; m_left--; end
      occ = occ + int'(acc) - int'(pop);
      if (fin) m_busy = 0;
      if (took) begin m_busy = 1; m_owner = 2'(o); end
      drained = !m_busy && occ == 0 && exp_done == 0;
      for (int i = 0; i < N; i++) if (shd[i] < sln[i]) drained = 0;
    end
    chk("rnd drained", drained, 1);
    chk("rnd leftover beats", expq.size(), 0);
    drive_idle();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    run_table();
    idle_cycles(2);
    run_backpressure();
    run_truncation();
    run_reset_mid();
`ifdef ARB_DISPATCH_TIMEOUT_EN
    run_timeout();
`endif
    idle_cycles(2);
    run_random();
    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
